// File: rtl/decryption_pkg.sv
// Definitions shared by the decryption engines: FSM states, the start token
// and default character/buffer sizes.
package decryption_pkg;

    localparam int CHAR_WIDTH        = 8;
    localparam int MAX_NOF_CHARS_DEF = 50;
    localparam logic [CHAR_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA;

    typedef enum logic {
        IDLE    = 1'b0,
        DECRYPT = 1'b1
    } dec_state_e;

endpackage

// File: rtl/scytale_char_buffer.sv
// Single-port character store with a registered read port; the read register
// returns 0 on cycles without a read so it can drive a data output directly.
module scytale_char_buffer #(
    parameter int DEPTH   = 50,
    parameter int D_WIDTH = 8,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [D_WIDTH-1:0] rdata_q
);

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [D_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/scytale_decryption.sv
// Scytale decryption engine: collects one ciphertext message, then on the
// start token replays it column-wise (scytale order) as plaintext.
module scytale_decryption #(
    parameter int D_WIDTH       = decryption_pkg::CHAR_WIDTH,
    parameter int KEY_WIDTH     = 8,
    parameter int MAX_NOF_CHARS = decryption_pkg::MAX_NOF_CHARS_DEF,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = decryption_pkg::START_DECRYPTION_TOKEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy,
    output logic                 err_o
);
    import decryption_pkg::*;

    localparam int IDX_W = $clog2(MAX_NOF_CHARS);
    localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
    localparam int PRD_W = 2 * KEY_WIDTH;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NOF_CHARS);

    dec_state_e state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [KEY_WIDTH-1:0] n_q, n_d, m_q, m_d;
    logic [KEY_WIDTH-1:0] c_q, c_d, r_q, r_d;
    logic [IDX_W-1:0]     addr_q, addr_d;
    logic                 drain_q, drain_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 we, re;
    logic [PRD_W-1:0]     prod;
    logic                 legal;

    assign prod  = PRD_W'(key_N) * PRD_W'(key_M);
    assign legal = (key_N != '0) && (key_M != '0) && (prod == PRD_W'(count_q)) && !ovf_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        n_d     = n_q;
        m_d     = m_q;
        c_d     = c_q;
        r_d     = r_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        err_d   = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (data_i != START_DECRYPTION_TOKEN) begin
                        if (count_q < MAX_CNT) begin
                            we      = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        n_d = key_N;
                        m_d = key_M;
                        if (legal) begin
                            state_d = DECRYPT;
                            addr_d  = '0;
                            c_d     = '0;
                            r_d     = '0;
                            drain_d = 1'b0;
                        end else begin
                            err_d   = 1'b1;
                            count_d = '0;
                            ovf_d   = 1'b0;
                        end
                    end
                end
            end
            DECRYPT: begin
                // drain cycle keeps busy high while the last character is on data_o
                if (drain_q) begin
                    state_d = IDLE;
                    drain_d = 1'b0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    c_d     = '0;
                    r_d     = '0;
                    addr_d  = '0;
                end else begin
                    re = 1'b1;
                    if (c_q == n_q - KEY_WIDTH'(1)) begin
                        c_d = '0;
                        if (r_q == m_q - KEY_WIDTH'(1)) begin
                            drain_d = 1'b1;
                        end else begin
                            r_d    = r_q + KEY_WIDTH'(1);
                            addr_d = IDX_W'(r_q) + IDX_W'(1);
                        end
                    end else begin
                        c_d    = c_q + KEY_WIDTH'(1);
                        addr_d = addr_q + IDX_W'(m_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = re;
        busy_d  = (state_d == DECRYPT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            n_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            addr_q  <= '0;
            drain_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            n_q     <= n_d;
            m_q     <= m_d;
            c_q     <= c_d;
            r_q     <= r_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    scytale_char_buffer #(
        .DEPTH   (MAX_NOF_CHARS),
        .D_WIDTH (D_WIDTH),
        .AW      (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (IDX_W'(count_q)),
        .wdata   (data_i),
        .re      (re),
        .raddr   (addr_q),
        .rdata_q (data_o)
    );

    assign valid_o = valid_q;
    assign busy    = busy_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_scytale_decryption.sv
// Bench for scytale_decryption: table of messages plus hand-written sequences
// for overflow, busy-time input, and asynchronous reset during replay.
module tb_scytale_decryption;

    localparam logic [7:0] TOKEN = 8'hFA;

    typedef byte unsigned bq_t[$];
    typedef struct {
        int    n;
        int    m;
        string msg;
        string exp;
        bit    err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_N;
    logic [7:0] key_M;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy;
    logic       err_o;

    int           n_checks = 0;
    int           n_fail   = 0;
    byte unsigned exp_q[$];
    byte unsigned mon_e;
    vec_t         tbl[9];

    always #5 clk = ~clk;

    scytale_decryption dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key_N   (key_N),
        .key_M   (key_M),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy    (busy),
        .err_o   (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Scoreboard: every valid_o cycle must match the next expected character.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %02h, required no output at %0t", data_o, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data_o", {24'd0, data_o}, {24'd0, mon_e});
                end
            end else begin
                check("data_o_idle_zero", {24'd0, data_o}, 32'd0);
            end
        end
    end

    task automatic send(input byte unsigned c);
        data_i  = c;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic run_msg(input string tag, input int n, input int m,
                           input bq_t msg, input bq_t exp, input bit err);
        int bc;
        key_N = 8'(n);
        key_M = 8'(m);
        foreach (msg[i]) send(msg[i]);
        foreach (exp[i]) exp_q.push_back(exp[i]);
        send(TOKEN);
        @(negedge clk);
        if (err) begin
            check({tag, "_err_pulse"}, {31'd0, err_o}, 32'd1);
            check({tag, "_err_busy"}, {31'd0, busy}, 32'd0);
            check({tag, "_err_valid"}, {31'd0, valid_o}, 32'd0);
            @(negedge clk);
            check({tag, "_err_one_cycle"}, {31'd0, err_o}, 32'd0);
        end else begin
            check({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
            check({tag, "_valid_latency"}, {31'd0, valid_o}, 32'd0);
            check({tag, "_no_err"}, {31'd0, err_o}, 32'd0);
            bc = 0;
            for (int i = 0; i < 200; i++) begin
                if (busy !== 1'b1) break;
                bc++;
                @(negedge clk);
            end
            check({tag, "_busy_len"}, 32'(bc), 32'(exp.size() + 1));
            check({tag, "_all_out"}, 32'(exp_q.size()), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t msg;
        bq_t exp;

        tbl[0] = '{2, 3, "ACEBDF", "ABCDEF", 1'b0};
        tbl[1] = '{2, 3, "ACEBD",  "",       1'b1};
        tbl[2] = '{2, 3, "ACEBDF", "ABCDEF", 1'b0};
        tbl[3] = '{3, 2, "STCAYL", "SCYTAL", 1'b0};
        tbl[4] = '{1, 4, "ABCD",   "ABCD",   1'b0};
        tbl[5] = '{4, 1, "WXYZ",   "WXYZ",   1'b0};
        tbl[6] = '{0, 3, "",       "",       1'b1};
        tbl[7] = '{3, 0, "",       "",       1'b1};
        tbl[8] = '{1, 1, "",       "",       1'b1};

        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        key_N   = 8'h00;
        key_M   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_data", {24'd0, data_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 9; t++) begin
            run_msg($sformatf("vec%0d", t), tbl[t].n, tbl[t].m,
                    s2q(tbl[t].msg), s2q(tbl[t].exp), tbl[t].err);
        end

        // Full buffer, legal 5x10 message
        msg.delete();
        exp.delete();
        for (int i = 0; i < 50; i++) msg.push_back(8'(8'h30 + i));
        for (int k = 0; k < 50; k++) exp.push_back(msg[(k % 5) * 10 + k / 5]);
        run_msg("full50", 5, 10, msg, exp, 1'b0);

        // Register-file reset value as key
        exp.delete();
        run_msg("key_ff", 255, 255, msg, exp, 1'b1);

        // 51 characters: overflow must reject, 51st never emitted
        msg.push_back(8'h7A);
        run_msg("overflow", 5, 10, msg, exp, 1'b1);
        run_msg("after_ovf", 1, 1, s2q("K"), s2q("K"), 1'b0);

        // Inputs and key changes during replay are ignored
        key_N = 8'd2;
        key_M = 8'd3;
        foreach (tbl[0].msg[i]) send(tbl[0].msg[i]);
        foreach (tbl[0].exp[i]) exp_q.push_back(tbl[0].exp[i]);
        send(TOKEN);
        for (int i = 0; i < 7; i++) begin
            check("busy_during_replay", {31'd0, busy}, 32'd1);
            data_i  = (i % 2 == 1) ? TOKEN : 8'h58;
            valid_i = 1'b1;
            key_N   = 8'(9 + i);
            key_M   = 8'd1;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
        @(negedge clk);
        check("busy_after_replay", {31'd0, busy}, 32'd0);
        check("replay_all_out", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        run_msg("after_busy", 1, 1, s2q("Q"), s2q("Q"), 1'b0);

        // Asynchronous reset on the third output cycle
        key_N = 8'd2;
        key_M = 8'd3;
        foreach (tbl[0].msg[i]) send(tbl[0].msg[i]);
        foreach (tbl[0].exp[i]) exp_q.push_back(tbl[0].exp[i]);
        send(TOKEN);
        repeat (3) @(posedge clk);
        #2;
        check("third_out_valid", {31'd0, valid_o}, 32'd1);
        check("third_out_data", {24'd0, data_o}, 32'h43);
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, valid_o}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_data", {24'd0, data_o}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_valid", {31'd0, valid_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_msg("post_reset", 1, 1, s2q("Z"), s2q("Z"), 1'b0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
